// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: the hardwired-zero
// register index, the default address type and packed-port slicing helpers.
package regfile_pkg;

  localparam int REG_ZERO = 0;

  localparam int DEF_NREG = 32;
  localparam int DEF_AW   = $clog2(DEF_NREG);

  typedef logic [DEF_AW-1:0] reg_addr_t;

  // Port i of a packed ra/rd vector occupies [port_lsb(i, width) +: width].
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

  function automatic int unsigned port_msb(input int unsigned port, input int unsigned width);
    return port * width + width - 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set by issue, cleared by
// writeback, with issue winning a same-edge collision; drives per-port busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr0,
  input  logic [AW-1:0]     clr0_addr,
  input  logic              clr1,
  input  logic [AW-1:0]     clr1_addr,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD-1:0]    busy,
  output logic [NREG-1:0]   pend_vec
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [AW-1:0]   look_addr;
  logic            look_hit;

  // Clears are applied first so a newer issue to the same register survives.
  always_comb begin
    pend_d = pend_q;
    if (clr0) pend_d[clr0_addr] = 1'b0;
    if (clr1) pend_d[clr1_addr] = 1'b0;
    if (set_en && (set_addr != AW'(REG_ZERO))) pend_d[set_addr] = 1'b1;
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // With bypass, a register whose producer is writing back right now is
  // already readable, so it is not reported busy.
  always_comb begin
    busy      = '0;
    look_addr = '0;
    look_hit  = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      look_addr = ra[port_lsb(i, AW) +: AW];
      look_hit  = (clr0 && (clr0_addr == look_addr)) ||
                  (clr1 && (clr1_addr == look_addr));
      busy[i]   = pend_q[look_addr] &&
                  !((BYPASS != 0) && look_hit) &&
                  (look_addr != AW'(REG_ZERO));
    end
  end

  assign pend_vec = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with two prioritised write ports, NRD
// combinational read ports, optional write-to-read bypass and a hazard scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW     = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DW-1:0]     wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DW-1:0]     wd1,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  output logic [NRD-1:0]    busy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  output logic [NREG-1:0]   pend_vec
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic          wen0;
  logic          wen1;
  logic          iss_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  // Writes to r0 and anything presented while reset is held are dropped.
  assign wen0   = we0 && (wa0 != AW'(REG_ZERO)) && !reset;
  assign wen1   = we1 && (wa1 != AW'(REG_ZERO)) && !reset;
  assign iss_en = iss_valid && !reset;

  // Port 1 is applied last so it owns a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (wen0) regs_d[wa0] = wd0;
    if (wen1) regs_d[wa1] = wd1;
    regs_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rd      = '0;
    rd_addr = '0;
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_addr = ra[port_lsb(i, AW) +: AW];
      rd_data = regs_q[rd_addr];
      if (BYPASS != 0) begin
        if (wen0 && (wa0 == rd_addr)) rd_data = wd0;
        if (wen1 && (wa1 == rd_addr)) rd_data = wd1;
      end
      if (rd_addr == AW'(REG_ZERO)) rd_data = '0;
      rd[port_lsb(i, DW) +: DW] = rd_data;
    end
  end

  regfile_scoreboard #(
    .NREG   (NREG),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .clr0      (wen0),
    .clr0_addr (wa0),
    .clr1      (wen1),
    .clr1_addr (wa1),
    .set_en    (iss_en),
    .set_addr  (iss_addr),
    .ra        (ra),
    .busy      (busy),
    .pend_vec  (pend_vec)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard-driven bench for regfile_mp: one bypassing and one non-bypassing
// instance share all inputs and are checked against queued expectations.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int NREG = 32;
  localparam int NRD = 2;
  localparam int AW = 5;

  localparam int K_RD = 0;
  localparam int K_RD_NB = 1;
  localparam int K_BUSY = 2;
  localparam int K_BUSY_NB = 3;
  localparam int K_PEND = 4;
  localparam int K_PEND_NB = 5;

  typedef struct {
    logic [95:0] tag;
    int          kind;
    int          port;
    logic [31:0] val;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              we0, we1;
  reg_addr_t         wa0, wa1;
  logic [DW-1:0]     wd0, wd1;
  logic [NRD*AW-1:0] ra;
  logic              iss_valid;
  reg_addr_t         iss_addr;
  logic [NRD*DW-1:0] rd, rd_nb;
  logic [NRD-1:0]    busy, busy_nb;
  logic [NREG-1:0]   pend_vec, pend_vec_nb;

  exp_t        sb_q[$];
  exp_t        e;
  logic [31:0] obs;
  int          total;
  int          bad;

  logic [31:0] m_mem [NREG];
  logic [31:0] m_pend;

  regfile_mp #(.DW(DW), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd), .busy(busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .pend_vec(pend_vec)
  );

  regfile_mp #(.DW(DW), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_nb), .busy(busy_nb),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .pend_vec(pend_vec_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] observe(input int kind, input int port);
    case (kind)
      K_RD:      return rd[port*DW +: DW];
      K_RD_NB:   return rd_nb[port*DW +: DW];
      K_BUSY:    return {31'b0, busy[port]};
      K_BUSY_NB: return {31'b0, busy_nb[port]};
      K_PEND:    return pend_vec;
      default:   return pend_vec_nb;
    endcase
  endfunction

  task automatic sb_push(input logic [95:0] tag, input int kind, input int port,
                         input logic [31:0] val);
    sb_q.push_back('{tag: tag, kind: kind, port: port, val: val});
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    iss_valid = 1'b0; iss_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    ra = '0;
    repeat (2) @(posedge clk);
    for (int a = 0; a < NREG; a++) begin
      @(negedge clk);
      ra = {5'(31 - a), 5'(a)};
      #1;
      for (int p = 0; p < NRD; p++) begin
        sb_push("rst_rd", K_RD, p, 32'h0);
        sb_push("rst_rd_nb", K_RD_NB, p, 32'h0);
        sb_push("rst_busy", K_BUSY, p, 32'h0);
        sb_push("rst_busy_nb", K_BUSY_NB, p, 32'h0);
      end
      sb_push("rst_pend", K_PEND, 0, 32'h0);
      sb_push("rst_pend_nb", K_PEND_NB, 0, 32'h0);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEADBEEF;
    iss_valid = 1'b1; iss_addr = 5'd0;
    ra = {5'd0, 5'd0};
    #1;
    sb_push("zero_byp", K_RD, 0, 32'h0);
    sb_push("zero_byp_nb", K_RD_NB, 0, 32'h0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    sb_push("zero_rd", K_RD, 0, 32'h0);
    sb_push("zero_rd_nb", K_RD_NB, 1, 32'h0);
    sb_push("zero_pend", K_PEND, 0, 32'h0);
    sb_push("zero_pend_nb", K_PEND_NB, 0, 32'h0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
  endtask

  task automatic test_write_ports();
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h22;
    ra = {5'd5, 5'd5};
    #1;
    sb_push("coll_byp0", K_RD, 0, 32'h22);
    sb_push("coll_byp1", K_RD, 1, 32'h22);
    sb_push("coll_old_nb", K_RD_NB, 1, 32'h0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hAAAA0010;
    we1 = 1'b1; wa1 = 5'd11; wd1 = 32'hBBBB0011;
    #1;
    sb_push("coll_rd", K_RD, 1, 32'h22);
    sb_push("coll_rd_nb", K_RD_NB, 1, 32'h22);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
    @(negedge clk);
    idle_inputs();
    ra = {5'd11, 5'd10};
    #1;
    sb_push("dual_r10", K_RD, 0, 32'hAAAA0010);
    sb_push("dual_r11", K_RD, 1, 32'hBBBB0011);
    sb_push("dual_r10_nb", K_RD_NB, 0, 32'hAAAA0010);
    sb_push("dual_r11_nb", K_RD_NB, 1, 32'hBBBB0011);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h1111;
    @(negedge clk);
    idle_inputs();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hA5A5;
    ra = {5'd7, 5'd0};
    #1;
    sb_push("byp_new", K_RD, 1, 32'hA5A5);
    sb_push("byp_old_nb", K_RD_NB, 1, 32'h1111);
    sb_push("byp_port0", K_RD, 0, 32'h0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    sb_push("byp_after", K_RD, 1, 32'hA5A5);
    sb_push("byp_after_nb", K_RD_NB, 1, 32'hA5A5);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    iss_valid = 1'b1; iss_addr = 5'd9;
    ra = {5'd9, 5'd9};
    #1;
    sb_push("sb_pre_busy", K_BUSY, 1, 32'h0);
    sb_push("sb_pre_pend", K_PEND, 0, 32'h0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    sb_push("sb_busy", K_BUSY, 1, 32'h1);
    sb_push("sb_busy_nb", K_BUSY_NB, 1, 32'h1);
    sb_push("sb_pend", K_PEND, 0, 32'h200);
    sb_push("sb_pend_nb", K_PEND_NB, 0, 32'h200);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
    #1;
    sb_push("wb_busy_byp", K_BUSY, 1, 32'h0);
    sb_push("wb_busy_nb", K_BUSY_NB, 1, 32'h1);
    sb_push("wb_rd_byp", K_RD, 1, 32'h99);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    sb_push("wb_pend", K_PEND, 0, 32'h0);
    sb_push("wb_pend_nb", K_PEND_NB, 0, 32'h0);
    sb_push("wb_busy_after", K_BUSY_NB, 1, 32'h0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
    @(negedge clk);
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h9A;
    iss_valid = 1'b1; iss_addr = 5'd9;
    @(negedge clk);
    idle_inputs();
    #1;
    sb_push("setwin_pend", K_PEND, 0, 32'h200);
    sb_push("setwin_pend_nb", K_PEND_NB, 0, 32'h200);
    sb_push("setwin_busy", K_BUSY, 0, 32'h1);
    sb_push("setwin_rd", K_RD_NB, 1, 32'h9A);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
    @(negedge clk);
    iss_valid = 1'b1; iss_addr = 5'd9;
    @(negedge clk);
    idle_inputs();
    #1;
    sb_push("reissue_pend", K_PEND, 0, 32'h200);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
    @(negedge clk);
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h9B;
    @(negedge clk);
    idle_inputs();
    #1;
    sb_push("clr1_pend", K_PEND, 0, 32'h0);
    sb_push("clr1_rd", K_RD, 1, 32'h9B);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1234;
    iss_valid = 1'b1; iss_addr = 5'd3;
    ra = {5'd0, 5'd3};
    @(negedge clk);
    idle_inputs();
    #1;
    sb_push("mid_pre_rd", K_RD, 0, 32'h1234);
    sb_push("mid_pre_rd_nb", K_RD_NB, 0, 32'h1234);
    sb_push("mid_pre_pend", K_PEND, 0, 32'h8);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
    #2;
    reset = 1'b1;
    #1;
    sb_push("mid_rd", K_RD, 0, 32'h0);
    sb_push("mid_rd_nb", K_RD_NB, 0, 32'h0);
    sb_push("mid_pend", K_PEND, 0, 32'h0);
    sb_push("mid_pend_nb", K_PEND_NB, 0, 32'h0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hBAD;
    iss_valid = 1'b1; iss_addr = 5'd4;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    sb_push("mid_drop_rd", K_RD, 0, 32'h0);
    sb_push("mid_drop_rd_nb", K_RD_NB, 0, 32'h0);
    sb_push("mid_drop_pend", K_PEND, 0, 32'h0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
  endtask

  task automatic test_random_traffic();
    logic [4:0]  a;
    logic [31:0] exp_b;
    logic        hit;
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    m_pend = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      we0 = ($urandom_range(0, 1) == 1); wa0 = 5'($urandom_range(0, 31)); wd0 = $urandom;
      we1 = ($urandom_range(0, 1) == 1); wa1 = 5'($urandom_range(0, 31)); wd1 = $urandom;
      iss_valid = ($urandom_range(0, 2) == 0); iss_addr = 5'($urandom_range(0, 31));
      ra = 10'($urandom_range(0, 1023));
      if (c % 5 == 0) ra[4:0] = wa0;
      if (c % 7 == 0) ra[9:5] = wa1;
      #1;
      for (int p = 0; p < NRD; p++) begin
        a = ra[p*AW +: AW];
        hit = (we0 && wa0 == a) || (we1 && wa1 == a);
        exp_b = m_mem[a];
        if (we0 && wa0 == a) exp_b = wd0;
        if (we1 && wa1 == a) exp_b = wd1;
        if (a == 5'd0) exp_b = '0;
        sb_push("rnd_rd", K_RD, p, exp_b);
        sb_push("rnd_rd_nb", K_RD_NB, p, (a == 5'd0) ? 32'h0 : m_mem[a]);
        sb_push("rnd_busy", K_BUSY, p, {31'b0, m_pend[a] && !hit && (a != 5'd0)});
        sb_push("rnd_busy_nb", K_BUSY_NB, p, {31'b0, m_pend[a] && (a != 5'd0)});
      end
      sb_push("rnd_pend", K_PEND, 0, m_pend);
      sb_push("rnd_pend_nb", K_PEND_NB, 0, m_pend);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
        if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
      end
      if (we0 && wa0 != 5'd0) begin m_mem[wa0] = wd0; m_pend[wa0] = 1'b0; end
      if (we1 && wa1 != 5'd0) begin m_mem[wa1] = wd1; m_pend[wa1] = 1'b0; end
      if (iss_valid && iss_addr != 5'd0) m_pend[iss_addr] = 1'b1;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    sb_push("rnd_final_pend", K_PEND, 0, m_pend);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); obs = observe(e.kind, e.port); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL %0s: got 0x%0h expected 0x%0h", e.tag, obs, e.val); end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    ra = '0;
    idle_inputs();
    $display("[TB] starting regfile_mp bench");
    test_reset();
    test_zero_reg();
    test_write_ports();
    test_bypass();
    test_scoreboard();
    test_mid_reset();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
